// File: rtl/button_step_conditioner.sv
// Two-button front end for the 4-bit step counter: synchronise, debounce, and turn
// presses into single-cycle up/down step pulses with hold-to-repeat and a both-pressed lockout.
//
// state     | meaning
// ST_IDLE   | waiting for a fresh debounced press
// ST_FIRST  | first pulse sent, counting the initial repeat delay
// ST_REPEAT | button still held, pulsing every REPEAT_RATE cycles
module button_step_conditioner #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int REPEAT_DELAY    = 64,
    parameter int REPEAT_RATE     = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic ena,
    input  logic btn_up,
    input  logic btn_dn,
    output logic up_pulse,
    output logic dn_pulse,
    output logic up_level,
    output logic dn_level,
    output logic lockout
);

    localparam int DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int TMR_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FIRST  = 2'd1,
        ST_REPEAT = 2'd2
    } step_state_e;

    // bit 0 = UP channel, bit 1 = DOWN channel
    logic [1:0]       btn_raw;
    logic [1:0]       sync1_q;
    logic [1:0]       sync2_q;
    logic [1:0]       level_q;
    logic [1:0]       level_d;
    logic [1:0]       level_prev_q;
    logic [DB_W-1:0]  db_cnt_q [2];
    logic [DB_W-1:0]  db_cnt_d [2];
    logic [TMR_W-1:0] timer_q  [2];
    step_state_e      state_q  [2];
    logic [1:0]       pulse_q;
    logic             lockout_q;
    logic             allowed;

    assign btn_raw = {btn_dn, btn_up};
    assign allowed = ena & ~lockout_q & ~(&level_q);

    always_comb begin
        level_d = level_q;
        for (int c = 0; c < 2; c++) begin
            db_cnt_d[c] = '0;
            if (sync2_q[c] != level_q[c]) begin
                if (db_cnt_q[c] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                    level_d[c] = sync2_q[c];
                end else begin
                    db_cnt_d[c] = db_cnt_q[c] + DB_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
            level_q <= '0;
            for (int c = 0; c < 2; c++) begin
                db_cnt_q[c] <= '0;
            end
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
            level_q <= level_d;
            for (int c = 0; c < 2; c++) begin
                db_cnt_q[c] <= db_cnt_d[c];
            end
        end
    end

    // Lockout is sticky until both buttons are fully released.
    always_ff @(posedge clk) begin
        if (rst) begin
            lockout_q <= 1'b0;
        end else if (&level_q) begin
            lockout_q <= 1'b1;
        end else if (~|level_q) begin
            lockout_q <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            level_prev_q <= '0;
            pulse_q      <= '0;
            for (int c = 0; c < 2; c++) begin
                state_q[c] <= ST_IDLE;
                timer_q[c] <= '0;
            end
        end else begin
            level_prev_q <= level_q;
            pulse_q      <= '0;
            for (int c = 0; c < 2; c++) begin
                if (!level_q[c] || !allowed) begin
                    state_q[c] <= ST_IDLE;
                    timer_q[c] <= '0;
                end else begin
                    case (state_q[c])
                        ST_IDLE: begin
                            // a level already high when stepping becomes allowed is not a press
                            if (!level_prev_q[c]) begin
                                pulse_q[c] <= 1'b1;
                                state_q[c] <= ST_FIRST;
                                timer_q[c] <= '0;
                            end
                        end
                        ST_FIRST: begin
                            if (timer_q[c] == TMR_W'(REPEAT_DELAY - 1)) begin
                                pulse_q[c] <= 1'b1;
                                state_q[c] <= ST_REPEAT;
                                timer_q[c] <= '0;
                            end else begin
                                timer_q[c] <= timer_q[c] + TMR_W'(1);
                            end
                        end
                        ST_REPEAT: begin
                            if (timer_q[c] == TMR_W'(REPEAT_RATE - 1)) begin
                                pulse_q[c] <= 1'b1;
                                timer_q[c] <= '0;
                            end else begin
                                timer_q[c] <= timer_q[c] + TMR_W'(1);
                            end
                        end
                        default: begin
                            state_q[c] <= ST_IDLE;
                            timer_q[c] <= '0;
                        end
                    endcase
                end
            end
        end
    end

    assign up_pulse = pulse_q[0];
    assign dn_pulse = pulse_q[1];
    assign up_level = level_q[0];
    assign dn_level = level_q[1];
    assign lockout  = lockout_q;

endmodule

// File: tb/tb_button_step_conditioner.sv
// Directed bench for button_step_conditioner with DEBOUNCE_CYCLES=4, REPEAT_DELAY=8, REPEAT_RATE=3.
// Tick i is the i-th rising edge after an input change; outputs are sampled 1ns after it.
module tb_button_step_conditioner;

    logic clk = 1'b0;
    logic rst;
    logic ena;
    logic btn_up;
    logic btn_dn;
    logic up_pulse;
    logic dn_pulse;
    logic up_level;
    logic dn_level;
    logic lockout;

    int checks = 0;
    int errors = 0;

    button_step_conditioner #(
        .DEBOUNCE_CYCLES (4),
        .REPEAT_DELAY    (8),
        .REPEAT_RATE     (3)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .ena      (ena),
        .btn_up   (btn_up),
        .btn_dn   (btn_dn),
        .up_pulse (up_pulse),
        .dn_pulse (dn_pulse),
        .up_level (up_level),
        .dn_level (dn_level),
        .lockout  (lockout)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        btn_up = 1'b0;
        btn_dn = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            tick();
            checks++;
            if (up_pulse !== 1'b0 || dn_pulse !== 1'b0) begin
                errors++;
                $display("FAIL settle_pulse tick %0d got up=%b dn=%b exp 0 0", i, up_pulse, dn_pulse);
            end
        end
        checks++;
        if ({up_level, dn_level, lockout} !== 3'b000) begin
            errors++;
            $display("FAIL settle_idle got %b exp 000", {up_level, dn_level, lockout});
        end
    endtask

    task automatic test_reset();
        logic exp_p;
        btn_up = 1'b1;
        rst    = 1'b1;
        for (int i = 1; i <= 2; i++) begin
            tick();
            checks++;
            if ({up_pulse, dn_pulse, up_level, dn_level, lockout} !== 5'b00000) begin
                errors++;
                $display("FAIL reset_outputs tick %0d got %b exp 00000", i,
                         {up_pulse, dn_pulse, up_level, dn_level, lockout});
            end
        end
        rst = 1'b0;
        for (int i = 1; i <= 7; i++) begin
            tick();
            exp_p = (i == 7);
            checks++;
            if (up_pulse !== exp_p) begin
                errors++;
                $display("FAIL reset_first_pulse tick %0d got %b exp %b", i, up_pulse, exp_p);
            end
        end
        btn_up = 1'b0;
        settle();
    endtask

    task automatic test_tap();
        logic exp_p;
        logic exp_l;
        btn_up = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            exp_p = (i == 7);
            exp_l = (i >= 6 && i <= 11);
            checks++;
            if (up_pulse !== exp_p || dn_pulse !== 1'b0) begin
                errors++;
                $display("FAIL tap_pulse tick %0d got up=%b dn=%b exp up=%b dn=0", i, up_pulse, dn_pulse, exp_p);
            end
            checks++;
            if (up_level !== exp_l) begin
                errors++;
                $display("FAIL tap_level tick %0d got %b exp %b", i, up_level, exp_l);
            end
            if (i == 6) btn_up = 1'b0;
        end
        settle();
    endtask

    task automatic test_bounce();
        logic exp_p;
        for (int i = 0; i < 20; i++) begin
            btn_dn = ((i / 2) % 2) == 0;
            tick();
            checks++;
            if (dn_pulse !== 1'b0 || dn_level !== 1'b0) begin
                errors++;
                $display("FAIL bounce_toggle step %0d got pulse=%b level=%b exp 0 0", i, dn_pulse, dn_level);
            end
        end
        btn_dn = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            tick();
            exp_p = (i == 7);
            checks++;
            if (dn_pulse !== exp_p || up_pulse !== 1'b0) begin
                errors++;
                $display("FAIL bounce_pulse tick %0d got dn=%b up=%b exp dn=%b up=0", i, dn_pulse, up_pulse, exp_p);
            end
        end
        btn_dn = 1'b0;
        settle();
    endtask

    task automatic test_hold_repeat();
        logic exp_p;
        logic exp_l;
        btn_up = 1'b1;
        for (int i = 1; i <= 55; i++) begin
            tick();
            exp_p = (i == 7) || (i >= 15 && i <= 46 && ((i - 15) % 3) == 0);
            exp_l = (i >= 6 && i <= 45);
            checks++;
            if (up_pulse !== exp_p || dn_pulse !== 1'b0) begin
                errors++;
                $display("FAIL repeat_pulse tick %0d got up=%b dn=%b exp up=%b dn=0", i, up_pulse, dn_pulse, exp_p);
            end
            checks++;
            if (up_level !== exp_l) begin
                errors++;
                $display("FAIL repeat_level tick %0d got %b exp %b", i, up_level, exp_l);
            end
            if (i == 40) btn_up = 1'b0;
        end
        settle();
    endtask

    task automatic test_reset_mid_press();
        logic exp_p;
        btn_up = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            tick();
            exp_p = (i == 7) || (i == 15);
            checks++;
            if (up_pulse !== exp_p) begin
                errors++;
                $display("FAIL midrst_pre tick %0d got %b exp %b", i, up_pulse, exp_p);
            end
        end
        rst = 1'b1;
        tick();
        checks++;
        if ({up_pulse, dn_pulse, up_level, dn_level, lockout} !== 5'b00000) begin
            errors++;
            $display("FAIL midrst_outputs got %b exp 00000", {up_pulse, dn_pulse, up_level, dn_level, lockout});
        end
        rst = 1'b0;
        for (int i = 1; i <= 7; i++) begin
            tick();
            exp_p = (i == 7);
            checks++;
            if (up_pulse !== exp_p || up_level !== (i >= 6)) begin
                errors++;
                $display("FAIL midrst_post tick %0d got pulse=%b level=%b exp pulse=%b level=%b",
                         i, up_pulse, up_level, exp_p, (i >= 6));
            end
        end
        btn_up = 1'b0;
        settle();
    endtask

    task automatic test_interlock();
        logic exp_p;
        btn_up = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            tick();
            exp_p = (i == 7);
            checks++;
            if (up_pulse !== exp_p) begin
                errors++;
                $display("FAIL lock_first tick %0d got %b exp %b", i, up_pulse, exp_p);
            end
        end
        btn_dn = 1'b1;
        for (int i = 8; i <= 30; i++) begin
            tick();
            checks++;
            if (up_pulse !== 1'b0 || dn_pulse !== 1'b0) begin
                errors++;
                $display("FAIL lock_pulses tick %0d got up=%b dn=%b exp 0 0", i, up_pulse, dn_pulse);
            end
            checks++;
            if (lockout !== (i >= 14) || dn_level !== (i >= 13)) begin
                errors++;
                $display("FAIL lock_set tick %0d got lockout=%b dn_level=%b exp %b %b",
                         i, lockout, dn_level, (i >= 14), (i >= 13));
            end
        end
        btn_dn = 1'b0;
        for (int j = 1; j <= 15; j++) begin
            tick();
            checks++;
            if (up_pulse !== 1'b0 || dn_pulse !== 1'b0 || lockout !== 1'b1 || dn_level !== (j < 6)) begin
                errors++;
                $display("FAIL lock_dn_release tick %0d got up=%b dn=%b lockout=%b dn_level=%b exp 0 0 1 %b",
                         j, up_pulse, dn_pulse, lockout, dn_level, (j < 6));
            end
        end
        btn_up = 1'b0;
        for (int j = 1; j <= 12; j++) begin
            tick();
            checks++;
            if (up_pulse !== 1'b0 || dn_pulse !== 1'b0 || lockout !== (j < 7) || up_level !== (j < 6)) begin
                errors++;
                $display("FAIL lock_clear tick %0d got up=%b dn=%b lockout=%b up_level=%b exp 0 0 %b %b",
                         j, up_pulse, dn_pulse, lockout, up_level, (j < 7), (j < 6));
            end
        end
        btn_up = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            tick();
            exp_p = (i == 7);
            checks++;
            if (up_pulse !== exp_p) begin
                errors++;
                $display("FAIL lock_repress tick %0d got %b exp %b", i, up_pulse, exp_p);
            end
        end
        btn_up = 1'b0;
        settle();
    endtask

    task automatic test_both_same();
        btn_up = 1'b1;
        btn_dn = 1'b1;
        for (int i = 1; i <= 15; i++) begin
            tick();
            checks++;
            if (up_pulse !== 1'b0 || dn_pulse !== 1'b0 || lockout !== (i >= 7) || up_level !== (i >= 6)) begin
                errors++;
                $display("FAIL both_same tick %0d got up=%b dn=%b lockout=%b up_level=%b exp 0 0 %b %b",
                         i, up_pulse, dn_pulse, lockout, up_level, (i >= 7), (i >= 6));
            end
        end
        settle();
    endtask

    task automatic test_enable();
        logic exp_p;
        ena    = 1'b0;
        btn_up = 1'b1;
        for (int i = 1; i <= 30; i++) begin
            tick();
            checks++;
            if (up_pulse !== 1'b0 || dn_pulse !== 1'b0 || up_level !== (i >= 6)) begin
                errors++;
                $display("FAIL ena_low tick %0d got up=%b dn=%b up_level=%b exp 0 0 %b",
                         i, up_pulse, dn_pulse, up_level, (i >= 6));
            end
        end
        ena = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            checks++;
            if (up_pulse !== 1'b0 || dn_pulse !== 1'b0) begin
                errors++;
                $display("FAIL ena_raise_held tick %0d got up=%b dn=%b exp 0 0", i, up_pulse, dn_pulse);
            end
        end
        settle();
        btn_up = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            tick();
            exp_p = (i == 7);
            checks++;
            if (up_pulse !== exp_p) begin
                errors++;
                $display("FAIL ena_repress tick %0d got %b exp %b", i, up_pulse, exp_p);
            end
        end
        btn_up = 1'b0;
        settle();
    endtask

    initial begin
        rst    = 1'b1;
        ena    = 1'b1;
        btn_up = 1'b0;
        btn_dn = 1'b0;
        test_reset();
        test_tap();
        test_bounce();
        test_hold_repeat();
        test_reset_mid_press();
        test_interlock();
        test_both_same();
        test_enable();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
